fir_bus_host: RTL and testbench
===============================

// Module: fir_bus_host
// PURPOSE
//  Clocked host-side master for the FIR filter's 10-bit shared-bus port (wr_in/rd_in/data_io).
//  Takes one sample per valid/ready handshake and writes it to the filter with a wr strobe.
//  Waits for the filter's combinational MAC chain to settle, then reads the result back with an rd strobe.
//  Presents the result as a one-cycle-valid output. Sits between the sample source and the FIR block.
// PARAMETERS
//  DATA_W      10  bus / sample / result width
//  SETUP_CYC   2   cycles data_io is driven before wr_out rises (1..255)
//  STROBE_CYC  4   wr_out and rd_out high time in cycles (2..255)
//  HOLD_CYC    2   cycles data_io is still driven after wr_out falls (1..255)
//  SETTLE_CYC  16  bus-released wait between wr_out fall+hold and rd_out rise (>=TURN_CYC, <=255)
//  TURN_CYC    2   bus-released wait after rd_out falls before the next drive (1..255)
// PORTS
//  clk_in            in     1       system clock, all logic on rising edge
//  rst_in            in     1       reset, asynchronous, active-low
//  sample_in         in     DATA_W  sample to write to the filter
//  sample_valid_in   in     1       sample_in is valid
//  sample_ready_out  out    1       host can accept a sample (high only in IDLE)
//  result_out        out    DATA_W  last value read from the filter
//  result_valid_out  out    1       one-cycle pulse: result_out was just updated
//  xfer_count_out    out    16      completed read-backs, wraps 0xFFFF->0x0000
//  wr_out            out    1       filter write strobe (to wr_in)
//  rd_out            out    1       filter read strobe (to rd_in)
//  data_io           inout  DATA_W  shared bus; driven only when drive_en=1, else 'z
// BEHAVIOUR
//  Reset (async, immediate): wr_out=0, rd_out=0, drive_en=0 (data_io='z), result_out=0, result_valid_out=0,
//  xfer_count_out=0, state=IDLE, sample_ready_out=1 once rst_in is released.
//  All outputs and drive_en are registered. One 8-bit down-counter cnt is reloaded on every state entry.
//  FSM:
//   IDLE    : ready=1; on sample_valid_in&&ready latch sample_in->dreg, drive_en=1, ->W_SETUP (cnt=SETUP_CYC)
//   W_SETUP : data_io=dreg; at cnt end wr_out=1, ->W_STRB (cnt=STROBE_CYC)
//   W_STRB  : at cnt end wr_out=0, ->W_HOLD (cnt=HOLD_CYC); the filter captures data on the wr rising edge
//   W_HOLD  : at cnt end drive_en=0, ->SETTLE (cnt=SETTLE_CYC)
//   SETTLE  : bus released; at cnt end rd_out=1, ->R_STRB (cnt=STROBE_CYC)
//   R_STRB  : on the last cycle capture data_io->result_out, pulse result_valid_out,
//             xfer_count_out+=1, rd_out=0, ->R_TURN (cnt=TURN_CYC)
//   R_TURN  : bus released; at cnt end ->IDLE
//  Latency: result_valid_out is high SETUP+HOLD+SETTLE+2*STROBE cycles after the accept edge (28 at defaults).
//  Next ready is TURN_CYC cycles later (throughput 1 sample per 30 cycles at defaults).
//  Bus-safety invariants:
//   - drive_en and rd_out are never both 1.
//   - drive_en=0 for >=TURN_CYC cycles on both sides of every rd_out high period.
//   - wr_out and rd_out are never both 1.
//  sample_in is sampled only at the accept edge; later changes have no effect on the transfer in flight.
//  sample_valid_in held high causes back-to-back transfers with no extra idle cycle beyond the IDLE accept cycle.
//  Reset mid-transfer: the transfer is abandoned, with no result pulse and no count increment.
//  The filter's own reset is separate; the host does not re-synchronise to it.
//  result_out holds its value until the next capture; result_valid_out is exactly one cycle wide.
// TESTING
//  1 Reset: assert rst_in=0 mid-clock -> wr_out=rd_out=0, data_io='z, result_out=0, xfer_count_out=0 with no clock edge.
//  2 Single transfer, behavioural filter model (latch on wr rise, drive value+1 while rd high);
//    sample_in=0x155 -> wr_out rises 2 cycles after accept, result_out=0x156 with result_valid_out 28 cycles after accept.
//  3 sample_valid_in held high, 8 ramp samples 0x000..0x007 -> results 0x001..0x008 in order, 30-cycle spacing;
//    assertion: no cycle with drive_en&&rd_out.
//  4 rst_in pulsed low during W_STRB -> data_io='z and wr_out=0 immediately; no result_valid_out; next transfer completes normally.
//  5 Preload 0xFFFE completed transfers (force or run) -> 2 more transfers -> xfer_count_out reads 0xFFFF then 0x0000.
//  6 Parameters SETUP=1 STROBE=2 HOLD=1 SETTLE=2 TURN=2 -> result_valid_out 8 cycles after accept; invariants still hold.

Source files
------------

// File: rtl/fir_bus_host_if.sv
// rtl/fir_bus_host_if.sv - sample/result handshake and FIR strobe signals of fir_bus_host
interface fir_bus_host_if #(
    parameter int DATA_W = 10
);
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid_in;
    logic              sample_ready_out;
    logic [DATA_W-1:0] result_out;
    logic              result_valid_out;
    logic [15:0]       xfer_count_out;
    logic              wr_out;
    logic              rd_out;

    modport master (
        input  sample_in,
        input  sample_valid_in,
        output sample_ready_out,
        output result_out,
        output result_valid_out,
        output xfer_count_out,
        output wr_out,
        output rd_out
    );

    modport slave (
        output sample_in,
        output sample_valid_in,
        input  sample_ready_out,
        input  result_out,
        input  result_valid_out,
        input  xfer_count_out,
        input  wr_out,
        input  rd_out
    );
endinterface

// File: rtl/fir_bus_host.sv
// rtl/fir_bus_host.sv - host master that writes a sample to the FIR shared bus and reads the result back
module fir_bus_host #(
    parameter int DATA_W     = 10,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2,
    parameter int SETTLE_CYC = 16,
    parameter int TURN_CYC   = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    fir_bus_host_if.master    bus,
    inout  wire  [DATA_W-1:0] data_io
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_W_SETUP = 3'd1;
    localparam logic [2:0] ST_W_STRB  = 3'd2;
    localparam logic [2:0] ST_W_HOLD  = 3'd3;
    localparam logic [2:0] ST_SETTLE  = 3'd4;
    localparam logic [2:0] ST_R_STRB  = 3'd5;
    localparam logic [2:0] ST_R_TURN  = 3'd6;

    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC);
    localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC);
    localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC);
    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC);
    // The IDLE accept cycle is itself a bus-released cycle, so R_TURN only covers the remainder.
    localparam logic [7:0] TURN_LD   = 8'(TURN_CYC - 1);

    logic [2:0]        state;
    logic [7:0]        cnt;
    logic              cnt_last;
    logic [DATA_W-1:0] dreg;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic [15:0]       xfer_cnt;
    logic              drive_en;
    logic              wr;
    logic              rd;
    logic              ready;

    assign cnt_last = (cnt <= 8'd1);

    assign data_io = drive_en ? dreg : {DATA_W{1'bz}};

    assign bus.sample_ready_out = ready;
    assign bus.result_out       = result;
    assign bus.result_valid_out = result_valid;
    assign bus.xfer_count_out   = xfer_cnt;
    assign bus.wr_out           = wr;
    assign bus.rd_out           = rd;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state        <= ST_IDLE;
            cnt          <= 8'd0;
            dreg         <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            xfer_cnt     <= 16'd0;
            drive_en     <= 1'b0;
            wr           <= 1'b0;
            rd           <= 1'b0;
            ready        <= 1'b1;
        end else begin
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.sample_valid_in && ready) begin
                        dreg     <= bus.sample_in;
                        drive_en <= 1'b1;
                        ready    <= 1'b0;
                        cnt      <= SETUP_LD;
                        state    <= ST_W_SETUP;
                    end
                end
                ST_W_SETUP: begin
                    if (cnt_last) begin
                        wr    <= 1'b1;
                        cnt   <= STROBE_LD;
                        state <= ST_W_STRB;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_W_STRB: begin
                    if (cnt_last) begin
                        wr    <= 1'b0;
                        cnt   <= HOLD_LD;
                        state <= ST_W_HOLD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_W_HOLD: begin
                    if (cnt_last) begin
                        drive_en <= 1'b0;
                        cnt      <= SETTLE_LD;
                        state    <= ST_SETTLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_last) begin
                        rd    <= 1'b1;
                        cnt   <= STROBE_LD;
                        state <= ST_R_STRB;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_R_STRB: begin
                    // The filter is still driving on this last strobe cycle, so sample it here.
                    if (cnt_last) begin
                        result       <= data_io;
                        result_valid <= 1'b1;
                        xfer_cnt     <= xfer_cnt + 16'd1;
                        rd           <= 1'b0;
                        if (TURN_LD == 8'd0) begin
                            ready <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            cnt   <= TURN_LD;
                            state <= ST_R_TURN;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_R_TURN: begin
                    if (cnt_last) begin
                        ready <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    drive_en <= 1'b0;
                    wr       <= 1'b0;
                    rd       <= 1'b0;
                    ready    <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_bus_host.sv
// tb/tb_fir_bus_host.sv - directed-vector bench for fir_bus_host with a behavioural FIR bus model
module tb_fir_bus_host;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_bus_host_if #(.DATA_W(10)) bus0 ();
    fir_bus_host_if #(.DATA_W(10)) bus1 ();
    wire [9:0] data0;
    wire [9:0] data1;

    fir_bus_host #(.DATA_W(10)) dut0 (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus0),
        .data_io(data0)
    );

    fir_bus_host #(
        .DATA_W(10), .SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1), .SETTLE_CYC(2), .TURN_CYC(2)
    ) dut1 (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus1),
        .data_io(data1)
    );

    // Filter model: capture on wr rise, return captured+1 while rd is high.
    logic [9:0] flt0 = 10'd0;
    logic [9:0] flt1 = 10'd0;
    always @(posedge bus0.wr_out) flt0 <= data0;
    always @(posedge bus1.wr_out) flt1 <= data1;
    assign data0 = bus0.rd_out ? flt0 + 10'd1 : {10{1'bz}};
    assign data1 = bus1.rd_out ? flt1 + 10'd1 : {10{1'bz}};

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: edge numbers of accepts, result pulses, wr rises, and bus-safety violations.
    int         cyc = 0;
    int         acc_t[2][64];
    int         acc_n[2]     = '{0, 0};
    logic [9:0] res_v[2][64];
    int         res_t[2][64];
    int         res_n[2]     = '{0, 0};
    int         wr_rise[2]   = '{0, 0};
    int         inv_err[2]   = '{0, 0};
    int         since_drv[2] = '{100, 100};
    int         since_rd[2]  = '{100, 100};
    logic       wr_prev[2]   = '{1'b0, 1'b0};
    logic       rd_prev[2]   = '{1'b0, 1'b0};
    logic       drv_prev[2]  = '{1'b0, 1'b0};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && bus0.sample_valid_in && bus0.sample_ready_out && acc_n[0] < 64) begin
            acc_t[0][acc_n[0]] = cyc + 1;
            acc_n[0]++;
        end
        if (rst && bus1.sample_valid_in && bus1.sample_ready_out && acc_n[1] < 64) begin
            acc_t[1][acc_n[1]] = cyc + 1;
            acc_n[1]++;
        end
    end

    task automatic mon(input int i, input logic wr, input logic rd, input logic drv,
                       input logic rv, input logic [9:0] res, input int turn);
        if (drv && rd) inv_err[i]++;
        if (wr && rd) inv_err[i]++;
        since_drv[i] = drv ? 0 : since_drv[i] + 1;
        since_rd[i]  = rd ? 0 : since_rd[i] + 1;
        if (rd && !rd_prev[i] && since_drv[i] < turn + 1) inv_err[i]++;
        if (drv && !drv_prev[i] && since_rd[i] < turn + 1) inv_err[i]++;
        if (wr && !wr_prev[i]) wr_rise[i] = cyc;
        if (rv && res_n[i] < 64) begin
            res_v[i][res_n[i]] = res;
            res_t[i][res_n[i]] = cyc;
            res_n[i]++;
        end
        wr_prev[i]  = wr;
        rd_prev[i]  = rd;
        drv_prev[i] = drv;
    endtask

    always @(negedge clk) begin
        mon(0, bus0.wr_out, bus0.rd_out, dut0.drive_en, bus0.result_valid_out, bus0.result_out, 2);
        mon(1, bus1.wr_out, bus1.rd_out, dut1.drive_en, bus1.result_valid_out, bus1.result_out, 2);
    end

    task automatic set_in(input int i, input logic [9:0] s, input logic v);
        if (i == 0) begin
            bus0.sample_in       = s;
            bus0.sample_valid_in = v;
        end else begin
            bus1.sample_in       = s;
            bus1.sample_valid_in = v;
        end
    endtask

    task automatic xfer(input int i, input logic [9:0] s, output logic [9:0] r,
                        output int lat, output int wlat, output bit ok);
        int na;
        int nr;
        na = acc_n[i];
        nr = res_n[i];
        ok = 1'b0; r = 10'd0; lat = -1; wlat = -1;
        @(negedge clk);
        set_in(i, s, 1'b1);
        for (int k = 0; k < 100 && acc_n[i] == na; k++) @(negedge clk);
        set_in(i, ~s, 1'b0);
        if (acc_n[i] == na) return;
        for (int k = 0; k < 100 && res_n[i] == nr; k++) @(negedge clk);
        if (res_n[i] == nr) return;
        r    = res_v[i][nr];
        lat  = res_t[i][nr] - acc_t[i][na];
        wlat = wr_rise[i] - acc_t[i][na];
        ok   = 1'b1;
        for (int k = 0; k < 6; k++) @(negedge clk);
    endtask

    task automatic burst(input int i, input int n, input int space, input logic [9:0] base);
        int na;
        int nr;
        na = acc_n[i];
        nr = res_n[i];
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            set_in(i, base + 10'(k), 1'b1);
            for (int w = 0; w < 100 && acc_n[i] == na + k; w++) @(negedge clk);
        end
        set_in(i, 10'h000, 1'b0);
        for (int w = 0; w < 60 * n && res_n[i] < nr + n; w++) @(negedge clk);
        check($sformatf("burst%0d_count", i), res_n[i] - nr, n);
        for (int k = 0; k < n && nr + k < res_n[i]; k++) begin
            check($sformatf("burst%0d_res%0d", i, k), int'(res_v[i][nr + k]),
                  int'(base + 10'(k) + 10'd1));
            if (k > 0)
                check($sformatf("burst%0d_gap%0d", i, k),
                      res_t[i][nr + k] - res_t[i][nr + k - 1], space);
        end
        for (int k = 0; k < 6; k++) @(negedge clk);
    endtask

    typedef struct {
        logic [9:0] sample;
        logic [9:0] result;
        int         lat;
        int         wlat;
    } vec_t;

    vec_t       vec[4];
    logic [9:0] r;
    int         lat;
    int         wlat;
    bit         ok;
    int         nr;
    int         na;

    initial begin
        vec[0] = '{10'h155, 10'h156, 28, 2};
        vec[1] = '{10'h000, 10'h001, 28, 2};
        vec[2] = '{10'h3FF, 10'h000, 28, 2};
        vec[3] = '{10'h2AA, 10'h2AB, 28, 2};

        set_in(0, 10'h000, 1'b0);
        set_in(1, 10'h000, 1'b0);

        // Asynchronous reset before any clock edge
        #2 rst = 1'b0;
        #1;
        check("rst0_wr", int'(bus0.wr_out), 0);
        check("rst0_rd", int'(bus0.rd_out), 0);
        check("rst0_drive", int'(dut0.drive_en), 0);
        check("rst0_result", int'(bus0.result_out), 0);
        check("rst0_valid", int'(bus0.result_valid_out), 0);
        check("rst0_count", int'(bus0.xfer_count_out), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst0_ready", int'(bus0.sample_ready_out), 1);

        for (int j = 0; j < 4; j++) begin
            xfer(0, vec[j].sample, r, lat, wlat, ok);
            check($sformatf("vec%0d_done", j), int'(ok), 1);
            check($sformatf("vec%0d_result", j), int'(r), int'(vec[j].result));
            check($sformatf("vec%0d_latency", j), lat, vec[j].lat);
            check($sformatf("vec%0d_wr_delay", j), wlat, vec[j].wlat);
        end
        check("vec_count", int'(bus0.xfer_count_out), 4);
        check("vec_hold_result", int'(bus0.result_out), 10'h2AB);
        check("vec_valid_low", int'(bus0.result_valid_out), 0);

        // Mid-clock reset wipes the result and count with no clock edge
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst1_result", int'(bus0.result_out), 0);
        check("rst1_count", int'(bus0.xfer_count_out), 0);
        check("rst1_wr", int'(bus0.wr_out), 0);
        check("rst1_rd", int'(bus0.rd_out), 0);
        @(negedge clk);
        rst = 1'b1;

        burst(0, 8, 30, 10'h000);

        // Reset during W_STRB abandons the transfer
        na = acc_n[0];
        nr = res_n[0];
        @(negedge clk);
        set_in(0, 10'h123, 1'b1);
        for (int w = 0; w < 100 && acc_n[0] == na; w++) @(negedge clk);
        set_in(0, 10'h000, 1'b0);
        for (int w = 0; w < 50 && !bus0.wr_out; w++) @(negedge clk);
        check("t4_wr_high", int'(bus0.wr_out), 1);
        #2 rst = 1'b0;
        #1;
        check("t4_wr_low", int'(bus0.wr_out), 0);
        check("t4_drive_off", int'(dut0.drive_en), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("t4_no_result", res_n[0] - nr, 0);
        check("t4_count", int'(bus0.xfer_count_out), 0);
        xfer(0, 10'h0AB, r, lat, wlat, ok);
        check("t4_next_result", int'(r), 10'h0AC);
        check("t4_next_latency", lat, 28);
        check("t4_next_count", int'(bus0.xfer_count_out), 1);

        // Counter wrap from a preloaded value
        @(negedge clk);
        force dut0.xfer_cnt = 16'hFFFE;
        @(negedge clk);
        release dut0.xfer_cnt;
        @(negedge clk);
        check("wrap_preload", int'(bus0.xfer_count_out), 16'hFFFE);
        xfer(0, 10'h011, r, lat, wlat, ok);
        check("wrap_ffff", int'(bus0.xfer_count_out), 16'hFFFF);
        xfer(0, 10'h022, r, lat, wlat, ok);
        check("wrap_0000", int'(bus0.xfer_count_out), 16'h0000);
        check("wrap_result", int'(r), 10'h023);

        // Short-timing instance
        xfer(1, 10'h07F, r, lat, wlat, ok);
        check("fast_done", int'(ok), 1);
        check("fast_result", int'(r), 10'h080);
        check("fast_latency", lat, 8);
        check("fast_wr_delay", wlat, 1);
        burst(1, 3, 10, 10'h100);
        check("fast_count", int'(bus1.xfer_count_out), 4);

        check("bus_safety0", inv_err[0], 0);
        check("bus_safety1", inv_err[1], 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

endmodule
